// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and state type for the 1x8 TDM demultiplexer
package tdm_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - modulo-8 slot counter with frame-sync reload
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load0,
    output logic [SLOT_W-1:0] slot,
    output logic              wrap
);

    // A reload means the current sample is slot 0, so the next one is slot 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (load0) begin
            slot <= SLOT_W'(1);
        end else if (en) begin
            slot <= slot + SLOT_W'(1);
        end
    end

    assign wrap = en & ~load0 & (slot == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux_1x8.sv
// rtl/tdm_demux_1x8.sv - serial TDM stream to registered 8-slot parallel frame
module tdm_demux_1x8
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in,
    input  logic                   en,
    input  logic                   sync,
    output logic [8*WIDTH-1:0]     out,
    output logic                   valid,
    output logic [SLOT_W-1:0]      slot,
    output logic                   locked,
    output logic                   sync_err
);

    tdm_state_t         state_q;
    tdm_state_t         state_d;
    logic [WIDTH-1:0]   shadow [NUM_SLOTS];
    logic [8*WIDTH-1:0] frame_d;
    logic [SLOT_W-1:0]  wr_idx;
    logic               cap;
    logic               load0;
    logic               wrap;
    logic               err_d;

    assign load0 = en & sync;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (cap),
        .load0 (load0),
        .slot  (slot),
        .wrap  (wrap)
    );

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        err_d   = 1'b0;
        wr_idx  = slot;
        if (en) begin
            if (sync) begin
                state_d = LOCKED;
                cap     = 1'b1;
                wr_idx  = '0;
                err_d   = (state_q == LOCKED) && (slot != '0);
            end else if (state_q == LOCKED) begin
                cap = 1'b1;
            end
        end
    end

    // The final slot goes straight from the input so out updates on the slot-7 edge.
    always_comb begin
        frame_d = '0;
        for (int k = 0; k < NUM_SLOTS - 1; k++) begin
            frame_d[k*WIDTH +: WIDTH] = shadow[k];
        end
        frame_d[(NUM_SLOTS-1)*WIDTH +: WIDTH] = in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            out      <= '0;
            valid    <= 1'b0;
            sync_err <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            valid    <= wrap;
            sync_err <= err_d;
            if (cap) begin
                shadow[wr_idx] <= in;
            end
            if (wrap) begin
                out <= frame_d;
            end
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb/tb_tdm_demux_1x8.sv - randomized scoreboard bench for tdm_demux_1x8
module tb_tdm_demux_1x8;

    localparam int W = 4;

    typedef struct {
        int                 cyc;
        logic [8*W-1:0]     data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [W-1:0]       in;
    logic               en;
    logic               sync;
    logic [8*W-1:0]     out;
    logic               valid;
    logic [2:0]         slot;
    logic               locked;
    logic               sync_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    exp_t           frame_q[$];
    int             err_q[$];
    bit             m_locked;
    int             m_slot;
    logic [W-1:0]   m_frame [8];
    logic [8*W-1:0] m_out;

    tdm_demux_1x8 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .en       (en),
        .sync     (sync),
        .out      (out),
        .valid    (valid),
        .slot     (slot),
        .locked   (locked),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_slot   = 0;
        m_out    = '0;
        for (int k = 0; k < 8; k++) m_frame[k] = '0;
        frame_q.delete();
        err_q.delete();
    endtask

    // Reference behaviour: track frame position and which slots belong to the frame.
    task automatic step(input bit e, input bit s, input logic [W-1:0] d);
        @(negedge clk);
        en   = e;
        sync = s;
        in   = d;
        if (e) begin
            if (s) begin
                if (m_locked && m_slot != 0) err_q.push_back(cyc + 1);
                m_frame[0] = d;
                m_slot     = 1;
                m_locked   = 1'b1;
            end else if (m_locked) begin
                m_frame[m_slot] = d;
                if (m_slot == 7) begin
                    logic [8*W-1:0] f;
                    for (int k = 0; k < 8; k++) f[k*W +: W] = m_frame[k];
                    m_out = f;
                    frame_q.push_back('{cyc + 1, f});
                    m_slot = 0;
                end else begin
                    m_slot++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        bit ev;
        bit ee;
        cyc++;
        #1;
        ev = (frame_q.size() > 0) && (frame_q[0].cyc == cyc);
        check("valid", 64'(valid), 64'(ev));
        if (ev) begin
            check("frame", 64'(out), 64'(frame_q[0].data));
            void'(frame_q.pop_front());
        end
        ee = (err_q.size() > 0) && (err_q[0] == cyc);
        check("sync_err", 64'(sync_err), 64'(ee));
        if (ee) void'(err_q.pop_front());
        check("locked", 64'(locked), 64'(m_locked));
        check("slot", 64'(slot), 64'(m_slot));
        check("out_hold", 64'(out), 64'(m_out));
    end

    initial begin
        logic [W-1:0] seq [8];
        rst  = 1'b1;
        en   = 1'b0;
        sync = 1'b0;
        in   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_out", 64'(out), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        rst = 1'b0;

        // Hunting: no sync, nothing captured.
        for (int i = 0; i < 5; i++) step(1, 0, W'(1));

        // Frame with the classic 1,0,1,1,0,0,1,0 pattern.
        seq = '{W'(1), W'(0), W'(1), W'(1), W'(0), W'(0), W'(1), W'(0)};
        for (int i = 0; i < 8; i++) step(1, i == 0, seq[i]);
        // Back-to-back all-ones frame without sync.
        for (int i = 0; i < 8; i++) step(1, 0, '1);
        step(0, 1, '0);

        // Resync at slot 4 discards the partial frame.
        for (int i = 0; i < 4; i++) step(1, 0, W'($urandom));
        step(1, 1, W'(9));
        for (int i = 0; i < 7; i++) step(1, 0, W'($urandom));

        // Gapped strobe: en alternates within a frame.
        for (int i = 0; i < 16; i++) step(i % 2 == 0, (i % 2 == 1), W'($urandom));

        // Asynchronous reset between edges at slot 5.
        step(1, 1, W'($urandom));
        for (int i = 0; i < 4; i++) step(1, 0, W'($urandom));
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_out", 64'(out), 64'd0);
        check("arst_locked", 64'(locked), 64'd0);
        check("arst_slot", 64'(slot), 64'd0);
        check("arst_valid", 64'(valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 0, W'($urandom));

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0, W'($urandom));
        end

        for (int i = 0; i < 3; i++) step(0, 0, '0);
        @(negedge clk);
        check("frames_pending", 64'(frame_q.size()), 64'd0);
        check("errs_pending", 64'(err_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
